// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: steps the external round-key generator
// over 10 rounds, keeps all 11 round keys and serves them on a read port.
module aes_key_sched_ctrl #(
  parameter int NROUNDS = 10,
  parameter int KW      = 128,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [0:KW-1] key_in,
  output logic          busy,
  output logic          done,
  output logic          keys_valid,
  output logic [0:KW-1] kg_key,
  output logic [31:0]   kg_rcon,
  input  logic [0:KW-1] kg_rkey,
  input  logic [AW-1:0] rd_addr,
  output logic [0:KW-1] rd_key
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [AW-1:0] LAST = AW'(NROUNDS);

  state_t        state;
  logic [7:0]    rc;
  logic [AW-1:0] round;
  logic [0:KW-1] slots [0:NROUNDS];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign kg_rcon = busy ? {rc, 24'h000000} : 32'h0;

  // Sequencer: accept a key in IDLE, then one round per cycle in EXPAND
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      kg_key     <= '0;
      rc         <= '0;
      round      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            kg_key     <= key_in;
            rc         <= 8'h01;
            round      <= AW'(1);
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          kg_key <= kg_rkey;
          rc     <= xtime(rc);
          round  <= round + AW'(1);
          if (round == LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  // Round-key storage; contents survive reset and are masked by keys_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && start)
        slots[0] <= key_in;
      else if (state == EXPAND)
        slots[round] <= kg_rkey;
    end
  end

  // Registered read port; zero unless a complete key set is held
  always_ff @(posedge clk) begin
    if (rst)
      rd_key <= '0;
    else if (keys_valid && rd_addr <= LAST)
      rd_key <= slots[rd_addr];
    else
      rd_key <= '0;
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl with a behavioural
// FIPS-197 round-key generator attached to the kg_* port.
module tb_aes_key_sched_ctrl;

  localparam logic [0:127] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] S1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] S10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] K2  = 128'h0;
  localparam logic [0:127] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [0:127] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [0:127] K4  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] F10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [0:127] key_in = '0;
  logic         busy, done, keys_valid;
  logic [0:127] kg_key, kg_rkey, rd_key;
  logic [31:0]  kg_rcon;
  logic [3:0]   rd_addr = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int           c;
    logic [127:0] v;
  } rd_t;

  int           exp_done [$];
  logic [31:0]  exp_rcon [$];
  rd_t          exp_rd [$];
  logic [127:0] ek [11];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .kg_key(kg_key), .kg_rcon(kg_rcon), .kg_rkey(kg_rkey),
    .rd_addr(rd_addr), .rd_key(rd_key)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] bs;
    logic [7:0] e;
    r  = 8'h01;
    bs = x;
    e  = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, bs);
      bs = gmul(bs, bs);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] next_rk(input logic [0:127] k,
                                           input logic [31:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[0:31];
    w1 = k[32:63];
    w2 = k[64:95];
    w3 = k[96:127];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    t  = t ^ rcon;
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign kg_rkey = next_rk(kg_key, kg_rcon);

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic expand(input logic [0:127] k);
    ek[0] = k;
    for (int i = 1; i < 11; i++)
      ek[i] = next_rk(ek[i-1], {RC[i-1], 24'h000000});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle in which done must be seen.
  task automatic go(input logic [0:127] k, output int dc);
    key_in = k;
    start  = 1'b1;
    for (int i = 0; i < 10; i++) exp_rcon.push_back({RC[i], 24'h000000});
    dc = cyc + 11;
    exp_done.push_back(dc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] want);
    rd_t e;
    rd_addr = a;
    e.c = cyc + 1;
    e.v = want;
    exp_rd.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: done timing, rcon per busy cycle, read responses
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_done.size() > 0 && exp_done[0] < cyc) begin
        chk("done_missing", 128'(cyc), 128'(exp_done[0]));
        void'(exp_done.pop_front());
      end
      if (done) begin
        if (exp_done.size() > 0) begin
          chk("done_cyc", 128'(cyc), 128'(exp_done[0]));
          void'(exp_done.pop_front());
        end else begin
          chk("done_unexpected", 128'(done), 128'(0));
        end
      end
      if (busy) begin
        if (exp_rcon.size() > 0) begin
          chk("rcon", 128'(kg_rcon), 128'(exp_rcon[0]));
          void'(exp_rcon.pop_front());
        end else begin
          chk("busy_unexpected", 128'(busy), 128'(0));
        end
      end else begin
        chk("rcon_idle", 128'(kg_rcon), 128'(0));
      end
      if (exp_rd.size() > 0 && exp_rd[0].c <= cyc) begin
        chk("rd_cyc", 128'(exp_rd[0].c), 128'(cyc));
        chk("rd_key", rd_key, exp_rd[0].v);
        void'(exp_rd.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int dc, dc2, a;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_kv", 128'(keys_valid), 128'(0));
    chk("rst_kg_key", kg_key, 128'(0));
    chk("rst_rcon", 128'(kg_rcon), 128'(0));
    chk("rst_rd_key", rd_key, 128'(0));
    mon_en = 1'b1;
    rd(4'd0, 128'(0));

    // FIPS-197 key, full read-back, out-of-range reads
    go(K1, dc);
    wait_until(dc);
    chk("kv_after_done", 128'(keys_valid), 128'(1));
    expand(K1);
    for (int i = 0; i < 11; i++) rd(4'(i), ek[i]);
    rd(4'd0, K1);
    rd(4'd1, S1);
    rd(4'd10, S10);
    rd(4'd11, 128'(0));
    rd(4'd10, S10);
    rd(4'd15, 128'(0));

    // Start pulses while busy are ignored; reads during expansion are zero
    go(K4, dc);
    a = dc - 10;
    rd(4'd10, 128'(0));
    wait_until(a + 2);
    key_in = K1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd(4'd0, 128'(0));
    wait_until(a + 6);
    key_in = K1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(dc);
    expand(K4);
    for (int i = 0; i < 11; i++) rd(4'(i), ek[i]);
    rd(4'd10, F10);

    // All-zero key
    go(K2, dc);
    wait_until(dc);
    rd(4'd0, K2);
    rd(4'd1, Z1);
    rd(4'd10, Z10);

    // Start in the done cycle
    go(K4, dc);
    wait_until(dc);
    go(K1, dc2);
    chk("b2b_done_gap", 128'(dc2 - dc), 128'(11));
    wait_until(dc2);
    expand(K1);
    for (int i = 0; i < 11; i++) rd(4'(i), ek[i]);

    // Reset in busy cycle 5
    go(K1, dc);
    a = dc - 10;
    wait_until(a + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rcon.delete();
    void'(exp_done.pop_back());
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_kv", 128'(keys_valid), 128'(0));
    chk("mid_rst_rcon", 128'(kg_rcon), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    for (int i = 0; i < 11; i++) rd(4'(i), 128'(0));
    go(K2, dc);
    wait_until(dc);
    rd(4'd1, Z1);
    rd(4'd10, Z10);

    repeat (15) @(negedge clk);
    chk("pending_done", 128'(exp_done.size()), 128'(0));
    chk("pending_rcon", 128'(exp_rcon.size()), 128'(0));
    chk("pending_rd", 128'(exp_rd.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
